inning_ctrl: RTL and testbench
==============================

# inning_ctrl

Game sequencer for the baseball electronic display. It tracks inning, half-inning (top/bottom) and both team scores. It pulses a clear to the ball/strike/out/base count datapath at every half-inning changeover and declares game over under regulation, walk-off and extra-inning rules. It sits above the count datapath: it consumes that datapath's third-out and run-scored pulses, and gates which events the datapath may accept.

## Interface
- NUM_INNINGS, 9, regulation innings (≥1)
- MAX_INNINGS, 12, last inning played before a tie is declared (≥NUM_INNINGS, ≤15)
- SCORE_W, 5, score counter width
- CHANGE_CYCLES, 4, changeover dead time in clocks (≥1)
- MERCY_INNING, 5, first inning where the mercy rule applies (only with INNING_MERCY_EN)
- MERCY_LEAD, 10, run lead that triggers the mercy rule (only with INNING_MERCY_EN)
- iCLK  in  1  clock; all logic is on the rising edge
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  one-cycle pulse that starts a new game; honoured only in IDLE or GAME_OVER
- iOUT3  in  1  one-cycle pulse: the third out of the current half-inning
- iRUN  in  1  one-cycle pulse: one run scored by the batting team
- oINNING  out  4  current inning, 1-based (0 in IDLE)
- oHALF  out  1  0 = top (away bats), 1 = bottom (home bats)
- oSCORE_AWAY  out  SCORE_W  away team score
- oSCORE_HOME  out  SCORE_W  home team score
- oCLEAR  out  1  one-cycle pulse that resets the count datapath
- oACTIVE  out  1  high in TOP/BOTTOM only; the datapath accepts events only while it is high
- oGAME_OVER  out  1  high in GAME_OVER

## Operation
- States: IDLE, TOP, BOTTOM, CHANGE, GAME_OVER.
- Reset values: IDLE, oINNING=0, oHALF=0, both scores 0, oCLEAR=0, oACTIVE=0, oGAME_OVER=0.
- IDLE or GAME_OVER, on iSTART: scores←0, oINNING←1, oHALF←0, oCLEAR pulses, next state TOP.
- TOP/BOTTOM, on iRUN: the batting team's score increments and saturates at 2^SCORE_W−1.
- Walk-off: in BOTTOM with oINNING≥NUM_INNINGS, if an iRUN makes home>away, go to GAME_OVER.
- TOP, on iOUT3:
  - if oINNING≥NUM_INNINGS and home>away, go to GAME_OVER (bottom half skipped);
  - otherwise go to CHANGE.
- BOTTOM, on iOUT3:
  - if oINNING≥NUM_INNINGS and away≠home, go to GAME_OVER;
  - else if oINNING==MAX_INNINGS, go to GAME_OVER (tie);
  - otherwise go to CHANGE.
- CHANGE: oCLEAR pulses on entry, then the block waits CHANGE_CYCLES clocks. On exit it toggles oHALF; when leaving a bottom half it also increments oINNING. Next state is TOP or BOTTOM to match the new half.
- Every path into GAME_OVER also pulses oCLEAR.
- iRUN and iOUT3 in the same cycle: the run is credited first, and all end-of-half decisions use the updated score.
- iRUN and iOUT3 outside TOP/BOTTOM are ignored. iSTART outside IDLE/GAME_OVER is ignored.
- Reset mid-game returns everything to the reset values immediately, with no oCLEAR pulse.

## Timing
- All outputs are registered. Every response appears on the clock edge after the triggering input pulse (latency 1).
- oCLEAR is high for exactly one cycle, and only in the first cycle of CHANGE, GAME_OVER or TOP-after-start.
- The CHANGE dwell is exactly CHANGE_CYCLES cycles. oACTIVE is low for that whole dwell.
- iOUT3 to the next half having oACTIVE=1 is CHANGE_CYCLES+1 edges.
- Input pulses are assumed synchronous and one cycle wide (already edge-detected upstream).

## Configuration
- INNING_MERCY_EN defined: at any end-of-half, with oINNING≥MERCY_INNING, the game goes to GAME_OVER in either of these cases:
  - after a bottom half, if |home−away|≥MERCY_LEAD;
  - after a top half, if home−away≥MERCY_LEAD.
- The mercy check is evaluated after the regulation rules, using the updated score.
- INNING_MERCY_EN undefined: no mercy logic; MERCY_INNING and MERCY_LEAD are unused.

## Structure
- Shared package: the state enum, the HALF_TOP/HALF_BOTTOM constants, and the default parameter constants.
- One sub-module, inning_sat_cnt: a SCORE_W-bit saturating up-counter with a synchronous clear, instantiated once per team.
- The changeover timer and the FSM stay inline.

## Test plan
- Reset, then iSTART → next edge: oINNING=1, oHALF=0, oACTIVE=1, oCLEAR high for one cycle; 3× iRUN gives oSCORE_AWAY=3.
- TOP, iOUT3 → oCLEAR for one cycle; oACTIVE=0 for 4 cycles; then oHALF=1 with oINNING unchanged. A BOTTOM iOUT3 then gives oINNING=2, oHALF=0.
- Away 2 / home 2, bottom 9th, iRUN → next edge oGAME_OVER=1 with home=3. Separately, away 1 / home 4 at top-9 iOUT3 → oGAME_OVER=1 and no bottom half is played.
- Tie 5–5 through inning 12 bottom, iOUT3 → oGAME_OVER=1, oINNING=12.
- iRUN and iOUT3 in the same cycle with home at 31 (SCORE_W=5) → home stays 31 (saturation), then changeover.
- With INNING_MERCY_EN, away 10 / home 0 after bottom 5 → GAME_OVER. Without the macro → play continues to TOP, inning 6.

Source files
------------

// File: rtl/inning_ctrl_pkg.sv
// Shared types and default parameters for the inning sequencer.
// Optional mercy rule is enabled with the INNING_MERCY_EN macro (see inning_ctrl).
package inning_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTop,
    StBottom,
    StChange,
    StGameOver
  } state_e;

  localparam logic HALF_TOP    = 1'b0;
  localparam logic HALF_BOTTOM = 1'b1;

  localparam int unsigned DEF_NUM_INNINGS   = 9;
  localparam int unsigned DEF_MAX_INNINGS   = 12;
  localparam int unsigned DEF_SCORE_W       = 5;
  localparam int unsigned DEF_CHANGE_CYCLES = 4;
  localparam int unsigned DEF_MERCY_INNING  = 5;
  localparam int unsigned DEF_MERCY_LEAD    = 10;

endpackage

// File: rtl/inning_sat_cnt.sv
// Saturating up-counter with synchronous clear; one instance per team score.
// count_next exposes the value the counter will load, for same-cycle decisions.
module inning_sat_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] CountMax = '1;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count != CountMax)) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/inning_ctrl.sv
// Baseball game sequencer: innings, halves, scores, changeover clear and end-of-game rules.
// Define INNING_MERCY_EN to add the mercy rule (MERCY_INNING / MERCY_LEAD).
module inning_ctrl
  import inning_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INNINGS   = DEF_NUM_INNINGS,
  parameter int unsigned MAX_INNINGS   = DEF_MAX_INNINGS,
  parameter int unsigned SCORE_W       = DEF_SCORE_W,
  parameter int unsigned CHANGE_CYCLES = DEF_CHANGE_CYCLES,
  parameter int unsigned MERCY_INNING  = DEF_MERCY_INNING,
  parameter int unsigned MERCY_LEAD    = DEF_MERCY_LEAD
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic               iOUT3,
  input  logic               iRUN,
  output logic [3:0]         oINNING,
  output logic               oHALF,
  output logic [SCORE_W-1:0] oSCORE_AWAY,
  output logic [SCORE_W-1:0] oSCORE_HOME,
  output logic               oCLEAR,
  output logic               oACTIVE,
  output logic               oGAME_OVER
);

  localparam int unsigned CntW = (CHANGE_CYCLES > 1) ? $clog2(CHANGE_CYCLES) : 1;
  localparam logic [CntW-1:0] TimerLast = CntW'(CHANGE_CYCLES - 1);
  localparam logic [3:0] NumInn = 4'(NUM_INNINGS);
  localparam logic [3:0] MaxInn = 4'(MAX_INNINGS);

  if ((NUM_INNINGS < 1) || (MAX_INNINGS < NUM_INNINGS) || (MAX_INNINGS > 15) ||
      (CHANGE_CYCLES < 1) || (MERCY_INNING < 1) || (MERCY_LEAD < 1)) begin : g_param_err
    $error("inning_ctrl: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic [3:0]        inning_q, inning_d;
  logic              half_q, half_d;
  logic              clear_q, clear_d;
  logic [CntW-1:0]   timer_q, timer_d;
  logic              clr_scores;
  logic              inc_away, inc_home;
  logic [SCORE_W-1:0] away_next, home_next;
  logic              late, top_over, bottom_over, walk_off;
  logic              mercy_top, mercy_bot;

  // Run credit is decoded separately so end-of-half logic sees the updated score.
  assign inc_away = iRUN && (state_q == StTop);
  assign inc_home = iRUN && (state_q == StBottom);

  inning_sat_cnt #(.W(SCORE_W)) u_away (
    .clk        (iCLK),
    .rst        (iRST),
    .clr        (clr_scores),
    .inc        (inc_away),
    .count      (oSCORE_AWAY),
    .count_next (away_next)
  );

  inning_sat_cnt #(.W(SCORE_W)) u_home (
    .clk        (iCLK),
    .rst        (iRST),
    .clr        (clr_scores),
    .inc        (inc_home),
    .count      (oSCORE_HOME),
    .count_next (home_next)
  );

`ifdef INNING_MERCY_EN
  int lead;
  logic mercy_inn;
  assign lead      = int'(home_next) - int'(away_next);
  assign mercy_inn = 32'(inning_q) >= MERCY_INNING;
  assign mercy_top = mercy_inn && (lead >= int'(MERCY_LEAD));
  assign mercy_bot = mercy_inn && ((lead >= int'(MERCY_LEAD)) || (-lead >= int'(MERCY_LEAD)));
`else
  assign mercy_top = 1'b0;
  assign mercy_bot = 1'b0;
`endif

  assign late        = inning_q >= NumInn;
  assign walk_off    = iRUN && late && (home_next > away_next);
  assign top_over    = (late && (home_next > away_next)) || mercy_top;
  assign bottom_over = (late && (home_next != away_next)) || (inning_q == MaxInn) || mercy_bot;

  always_comb begin
    state_d    = state_q;
    inning_d   = inning_q;
    half_d     = half_q;
    clear_d    = 1'b0;
    timer_d    = timer_q;
    clr_scores = 1'b0;
    unique case (state_q)
      StIdle, StGameOver: begin
        if (iSTART) begin
          clr_scores = 1'b1;
          inning_d   = 4'd1;
          half_d     = HALF_TOP;
          clear_d    = 1'b1;
          state_d    = StTop;
        end
      end
      StTop: begin
        if (iOUT3) begin
          clear_d = 1'b1;
          timer_d = '0;
          state_d = top_over ? StGameOver : StChange;
        end
      end
      StBottom: begin
        if (walk_off) begin
          clear_d = 1'b1;
          state_d = StGameOver;
        end else if (iOUT3) begin
          clear_d = 1'b1;
          timer_d = '0;
          state_d = bottom_over ? StGameOver : StChange;
        end
      end
      StChange: begin
        if (timer_q == TimerLast) begin
          half_d  = ~half_q;
          state_d = (half_q == HALF_BOTTOM) ? StTop : StBottom;
          if (half_q == HALF_BOTTOM) begin
            inning_d = inning_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= StIdle;
      inning_q <= 4'd0;
      half_q   <= HALF_TOP;
      clear_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      inning_q <= inning_d;
      half_q   <= half_d;
      clear_q  <= clear_d;
      timer_q  <= timer_d;
    end
  end

  assign oINNING    = inning_q;
  assign oHALF      = half_q;
  assign oCLEAR     = clear_q;
  assign oACTIVE    = (state_q == StTop) || (state_q == StBottom);
  assign oGAME_OVER = state_q == StGameOver;

endmodule

// File: tb/tb_inning_ctrl.sv
// Self-checking bench for inning_ctrl: directed game scenarios plus random play
// against a game-rule reference model (mercy rule follows INNING_MERCY_EN).
module tb_inning_ctrl;

  localparam int NUM   = 9;
  localparam int MAXI  = 12;
  localparam int SW    = 5;
  localparam int CC    = 4;
  localparam int MINN  = 5;
  localparam int MLEAD = 10;
  localparam int SMAX  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, out3, run;
  logic [3:0]    inning;
  logic          half;
  logic [SW-1:0] away, home;
  logic          clear, active, over;

  inning_ctrl #(
    .NUM_INNINGS   (NUM),
    .MAX_INNINGS   (MAXI),
    .SCORE_W       (SW),
    .CHANGE_CYCLES (CC),
    .MERCY_INNING  (MINN),
    .MERCY_LEAD    (MLEAD)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iSTART      (start),
    .iOUT3       (out3),
    .iRUN        (run),
    .oINNING     (inning),
    .oHALF       (half),
    .oSCORE_AWAY (away),
    .oSCORE_HOME (home),
    .oCLEAR      (clear),
    .oACTIVE     (active),
    .oGAME_OVER  (over)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Game-level reference: who bats, the scores, and how many dead cycles remain.
  bit m_started, m_over, m_half, m_clear;
  int m_inning, m_away, m_home, m_change_left;

  function automatic bit m_active();
    return m_started && !m_over && (m_change_left == 0);
  endfunction

  task automatic model_reset();
    m_started = 0; m_over = 0; m_half = 0; m_clear = 0;
    m_inning = 0; m_away = 0; m_home = 0; m_change_left = 0;
  endtask

  function automatic bit game_ends_after_half();
    int lead = m_home - m_away;
    if (!m_half && m_inning >= NUM && lead > 0) return 1;
    if (m_half && m_inning >= NUM && lead != 0) return 1;
    if (m_half && m_inning == MAXI) return 1;
`ifdef INNING_MERCY_EN
    if (m_inning >= MINN) begin
      if (m_half && (lead >= MLEAD || -lead >= MLEAD)) return 1;
      if (!m_half && lead >= MLEAD) return 1;
    end
`endif
    return 0;
  endfunction

  task automatic model_step(input bit s, input bit r, input bit o);
    m_clear = 0;
    if (m_change_left > 0) begin
      m_change_left--;
      if (m_change_left == 0) begin
        if (m_half) m_inning++;
        m_half = !m_half;
      end
    end else if (m_active()) begin
      if (r) begin
        if (m_half) m_home = (m_home + 1 > SMAX) ? SMAX : m_home + 1;
        else        m_away = (m_away + 1 > SMAX) ? SMAX : m_away + 1;
      end
      if (r && m_half && m_inning >= NUM && m_home > m_away) begin
        m_over = 1; m_clear = 1;
      end else if (o) begin
        m_clear = 1;
        if (game_ends_after_half()) m_over = 1;
        else m_change_left = CC;
      end
    end else if (s) begin
      m_started = 1; m_over = 0; m_inning = 1; m_half = 0;
      m_away = 0; m_home = 0; m_clear = 1;
    end
  endtask

  task automatic step(input bit s, input bit r, input bit o);
    @(negedge clk);
    start = s; run = r; out3 = o;
    @(posedge clk);
    model_step(s, r, o);
    #1;
    start = 0; run = 0; out3 = 0;
  endtask

  task automatic play_half(input int nruns);
    repeat (nruns) step(0, 1, 0);
    step(0, 0, 1);
    if (!m_over) repeat (CC) step(0, 0, 0);
  endtask

  task automatic new_game();
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 0;
    step(1, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; run = 0; out3 = 0;
    model_reset();
    #2;
    n_cmp++;
    if ({inning, half, away, home, clear, active, over} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got inn=%0d half=%0d away=%0d home=%0d clr=%0d act=%0d over=%0d want all 0",
               inning, half, away, home, clear, active, over);
    end
    @(negedge clk);
    rst = 0;
    step(0, 1, 1);
    n_cmp++;
    if (active !== 1'b0 || inning !== 4'd0 || away !== '0 || clear !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_events: got act=%0d inn=%0d away=%0d clr=%0d want 0 0 0 0",
               active, inning, away, clear);
    end
  endtask

  task automatic test_start();
    step(1, 0, 0);
    n_cmp++;
    if (inning !== 4'd1 || half !== 1'b0 || active !== 1'b1 || clear !== 1'b1) begin
      n_fail++;
      $display("FAIL start: got inn=%0d half=%0d act=%0d clr=%0d want 1 0 1 1",
               inning, half, active, clear);
    end
    step(0, 0, 0);
    n_cmp++;
    if (clear !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clear_width: got clr=%0d want 0", clear);
    end
    repeat (3) step(0, 1, 0);
    n_cmp++;
    if (away !== SW'(3) || home !== '0) begin
      n_fail++;
      $display("FAIL away_runs: got away=%0d home=%0d want 3 0", away, home);
    end
  endtask

  task automatic test_changeover();
    step(0, 0, 1);
    n_cmp++;
    if (clear !== 1'b1 || active !== 1'b0 || over !== 1'b0) begin
      n_fail++;
      $display("FAIL top_out3: got clr=%0d act=%0d over=%0d want 1 0 0", clear, active, over);
    end
    for (int i = 1; i < CC; i++) begin
      if (i == 1) step(1, 1, 0);
      else step(0, 0, 0);
      n_cmp++;
      if (active !== 1'b0 || clear !== 1'b0 || away !== SW'(3) || half !== 1'b0) begin
        n_fail++;
        $display("FAIL dwell_%0d: got act=%0d clr=%0d away=%0d half=%0d want 0 0 3 0",
                 i, active, clear, away, half);
      end
    end
    step(0, 0, 0);
    n_cmp++;
    if (active !== 1'b1 || half !== 1'b1 || inning !== 4'd1) begin
      n_fail++;
      $display("FAIL to_bottom: got act=%0d half=%0d inn=%0d want 1 1 1", active, half, inning);
    end
    play_half(0);
    n_cmp++;
    if (active !== 1'b1 || half !== 1'b0 || inning !== 4'd2) begin
      n_fail++;
      $display("FAIL to_top2: got act=%0d half=%0d inn=%0d want 1 0 2", active, half, inning);
    end
  endtask

  task automatic test_walkoff();
    new_game();
    play_half(2);
    play_half(2);
    for (int i = 2; i <= 8; i++) begin
      play_half(0);
      play_half(0);
    end
    play_half(0);
    n_cmp++;
    if (inning !== 4'd9 || half !== 1'b1 || active !== 1'b1 || away !== SW'(2) || home !== SW'(2)) begin
      n_fail++;
      $display("FAIL bottom9_setup: got inn=%0d half=%0d act=%0d away=%0d home=%0d want 9 1 1 2 2",
               inning, half, active, away, home);
    end
    step(0, 1, 0);
    n_cmp++;
    if (over !== 1'b1 || home !== SW'(3) || clear !== 1'b1 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL walkoff: got over=%0d home=%0d clr=%0d act=%0d want 1 3 1 0",
               over, home, clear, active);
    end
    step(0, 1, 1);
    n_cmp++;
    if (over !== 1'b1 || clear !== 1'b0 || home !== SW'(3)) begin
      n_fail++;
      $display("FAIL walkoff_hold: got over=%0d clr=%0d home=%0d want 1 0 3", over, clear, home);
    end
  endtask

  task automatic test_top9_end();
    new_game();
    play_half(1);
    play_half(4);
    for (int i = 2; i <= 8; i++) begin
      play_half(0);
      play_half(0);
    end
    step(0, 0, 1);
    n_cmp++;
    if (over !== 1'b1 || half !== 1'b0 || inning !== 4'd9 || clear !== 1'b1) begin
      n_fail++;
      $display("FAIL top9_home_leads: got over=%0d half=%0d inn=%0d clr=%0d want 1 0 9 1",
               over, half, inning, clear);
    end
    repeat (CC + 1) step(0, 0, 0);
    n_cmp++;
    if (over !== 1'b1 || half !== 1'b0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bottom9: got over=%0d half=%0d act=%0d want 1 0 0", over, half, active);
    end
  endtask

  task automatic test_tie12();
    new_game();
    play_half(5);
    play_half(5);
    for (int i = 2; i <= 11; i++) begin
      play_half(0);
      play_half(0);
    end
    play_half(0);
    n_cmp++;
    if (over !== 1'b0 || inning !== 4'd12 || half !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_reaches_b12: got over=%0d inn=%0d half=%0d want 0 12 1", over, inning, half);
    end
    step(0, 0, 1);
    n_cmp++;
    if (over !== 1'b1 || inning !== 4'd12 || away !== SW'(5) || home !== SW'(5)) begin
      n_fail++;
      $display("FAIL tie12: got over=%0d inn=%0d away=%0d home=%0d want 1 12 5 5",
               over, inning, away, home);
    end
  endtask

  task automatic test_saturation();
    new_game();
    play_half(0);
    repeat (SMAX + 2) step(0, 1, 0);
    n_cmp++;
    if (home !== SW'(SMAX)) begin
      n_fail++;
      $display("FAIL sat_runs: got home=%0d want %0d", home, SMAX);
    end
    step(0, 1, 1);
    n_cmp++;
    if (home !== SW'(SMAX) || clear !== 1'b1 || active !== 1'b0 || over !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_run_out3: got home=%0d clr=%0d act=%0d over=%0d want %0d 1 0 0",
               home, clear, active, over, SMAX);
    end
    repeat (CC) step(0, 0, 0);
    n_cmp++;
    if (inning !== 4'd2 || half !== 1'b0 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_next_inning: got inn=%0d half=%0d act=%0d want 2 0 1", inning, half, active);
    end
  endtask

  task automatic test_mercy();
    bit exp_over;
`ifdef INNING_MERCY_EN
    exp_over = 1;
`else
    exp_over = 0;
`endif
    new_game();
    play_half(10);
    play_half(0);
    for (int i = 2; i <= 4; i++) begin
      play_half(0);
      play_half(0);
    end
    play_half(0);
    step(0, 0, 1);
    n_cmp++;
    if (over !== exp_over || clear !== 1'b1) begin
      n_fail++;
      $display("FAIL mercy_b5: got over=%0d clr=%0d want %0d 1", over, clear, exp_over);
    end
    repeat (CC) step(0, 0, 0);
    n_cmp++;
    if (over !== exp_over || inning !== (exp_over ? 4'd5 : 4'd6) || active !== !exp_over) begin
      n_fail++;
      $display("FAIL mercy_after: got over=%0d inn=%0d act=%0d want %0d %0d %0d",
               over, inning, active, exp_over, exp_over ? 5 : 6, !exp_over);
    end
  endtask

  task automatic test_reset_midgame();
    new_game();
    repeat (2) step(0, 1, 0);
    step(0, 0, 1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    model_reset();
    n_cmp++;
    if ({inning, half, away, home, clear, active, over} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got inn=%0d half=%0d away=%0d home=%0d clr=%0d act=%0d over=%0d want all 0",
               inning, half, away, home, clear, active, over);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (clear !== 1'b0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got clr=%0d act=%0d want 0 0", clear, active);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_random();
    int run_div;
    new_game();
    for (int seg = 0; seg < 6; seg++) begin
      run_div = (seg % 2 == 1) ? 2 : 5;
      for (int c = 0; c < 600; c++) begin
        step(($urandom % 40) == 0, ($urandom % run_div) == 0, ($urandom % 7) == 0);
        n_cmp++;
        if (inning !== 4'(m_inning) || half !== m_half || away !== SW'(m_away) ||
            home !== SW'(m_home) || clear !== m_clear || active !== m_active() ||
            over !== m_over) begin
          n_fail++;
          $display("FAIL random_c%0d: got inn=%0d half=%0d a=%0d h=%0d clr=%0d act=%0d over=%0d want %0d %0d %0d %0d %0d %0d %0d",
                   seg * 600 + c, inning, half, away, home, clear, active, over,
                   m_inning, m_half, m_away, m_home, m_clear, m_active(), m_over);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_changeover();
    test_walkoff();
    test_top9_end();
    test_tie12();
    test_saturation();
    test_mercy();
    test_reset_midgame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
